// File: rtl/sram_pkg.sv
// Shared definitions for the 256x288 masked single-port SRAM front end.
// Holds the macro geometry, the arbiter state encoding and the request record
// used to steer one requester onto the macro port.
package sram_pkg;

  localparam int unsigned SRAM_AW = 8;    // address bits, 256 words
  localparam int unsigned SRAM_DW = 288;  // word width
  localparam int unsigned SRAM_MW = 32;   // write-mask lanes
  localparam int unsigned SRAM_LW = SRAM_DW / SRAM_MW;  // 9 bits per lane

  typedef enum logic [2:0] {
    StRstIdle,
    StInit,
    StRun,
    StVSwitch,
    StVSettle
  } state_e;

  typedef struct packed {
    logic               write;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
    logic [SRAM_MW-1:0] wmask;
  } req_t;

endpackage

// File: rtl/sram_1rwm_arbiter_if.sv
// One requester port of the SRAM front end.
//   valid/write/addr/wdata/wmask : request, driven by the requester (master)
//   ready                        : request accepted this cycle (grant)
//   rvalid                       : read data valid on the shared rdata bus
interface sram_1rwm_arbiter_if #(
  parameter int unsigned AW = sram_pkg::SRAM_AW,
  parameter int unsigned DW = sram_pkg::SRAM_DW,
  parameter int unsigned MW = sram_pkg::SRAM_MW
) ();

  logic          valid;
  logic          ready;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [MW-1:0] wmask;
  logic          rvalid;

  modport master (
    output valid, write, addr, wdata, wmask,
    input  ready, rvalid
  );

  modport slave (
    input  valid, write, addr, wdata, wmask,
    output ready, rvalid
  );

endinterface

// File: rtl/sram_1rwm_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a last-winner pointer.
//   i_clock, i_reset_n : clock, asynchronous active-low reset
//   i_en               : grants allowed this cycle
//   i_req[1:0]         : requests, bit 0 = A, bit 1 = B
//   o_gnt[1:0]         : one-hot (or zero) grant, combinational
module rr_arb2 (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // 1 = B won last, so A wins the first tie after reset.
  logic r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_ptr ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr <= 1'b1;
    end else if (o_gnt[1]) begin
      r_ptr <= 1'b1;
    end else if (o_gnt[0]) begin
      r_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_1rwm_arbiter.sv
// Two-requester front end for a 256x288 single-port masked SRAM macro.
// Zero-fills the array after reset, then shares the RW port between A and B
// with round-robin arbitration, returns read data one cycle after the grant,
// and keeps the macro idle around volt_sel changes.
//   i_clock, i_reset_n     : clock, asynchronous active-low reset
//   io_a, io_b             : requester ports (slave side)
//   o_rdata                : read data shared by both requesters
//   o_init_done            : zero-fill complete
//   i_volt_req, o_volt_sel : requested / applied voltage select
//   o_sram_*, i_sram_rdata : macro port
module sram_1rwm_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned AW            = SRAM_AW,
  parameter int unsigned DW            = SRAM_DW,
  parameter int unsigned MW            = SRAM_MW,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned INIT_ZERO     = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  sram_1rwm_arbiter_if.slave    io_a,
  sram_1rwm_arbiter_if.slave    io_b,
  output logic [DW-1:0]         o_rdata,
  output logic                  o_init_done,
  input  logic                  i_volt_req,
  output logic                  o_sram_valid,
  output logic                  o_sram_write,
  output logic [AW-1:0]         o_sram_addr,
  output logic [DW-1:0]         o_sram_wdata,
  output logic [MW-1:0]         o_sram_wmask,
  input  logic [DW-1:0]         i_sram_rdata,
  output logic                  o_volt_sel
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e        r_state;
  logic [AW-1:0] r_cnt;
  logic [SW-1:0] r_settle;
  logic          r_volt_sel;
  logic          r_init_done;
  logic          r_a_rvalid;
  logic          r_b_rvalid;

  logic          w_run_en;
  logic [1:0]    w_gnt;
  req_t          w_a_req;
  req_t          w_b_req;
  req_t          w_mux;

  // A pending voltage change blocks every grant in the cycle it is seen.
  assign w_run_en = (r_state == StRun) && (i_volt_req == r_volt_sel);

  rr_arb2 u_arb (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_en      (w_run_en),
    .i_req     ({io_b.valid, io_a.valid}),
    .o_gnt     (w_gnt)
  );

  assign w_a_req = '{write: io_a.write, addr: io_a.addr, wdata: io_a.wdata, wmask: io_a.wmask};
  assign w_b_req = '{write: io_b.write, addr: io_b.addr, wdata: io_b.wdata, wmask: io_b.wmask};

  always_comb begin
    w_mux = w_gnt[1] ? w_b_req : w_a_req;
    if (r_state == StInit) begin
      w_mux = '{write: 1'b1, addr: r_cnt, wdata: '0, wmask: '1};
    end
  end

  assign o_sram_valid = (r_state == StInit) || (|w_gnt);
  assign o_sram_write = o_sram_valid && w_mux.write;
  assign o_sram_addr  = w_mux.addr;
  assign o_sram_wdata = w_mux.wdata;
  assign o_sram_wmask = w_mux.wmask;

  assign io_a.ready  = w_gnt[0];
  assign io_b.ready  = w_gnt[1];
  assign io_a.rvalid = r_a_rvalid;
  assign io_b.rvalid = r_b_rvalid;
  assign o_rdata     = i_sram_rdata;
  assign o_init_done = r_init_done;
  assign o_volt_sel  = r_volt_sel;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StRstIdle;
      r_cnt       <= '0;
      r_settle    <= '0;
      r_volt_sel  <= 1'b0;
      r_init_done <= 1'b0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
    end else begin
      // Macro read latency is one cycle, so the response flag is the grant delayed.
      r_a_rvalid <= w_gnt[0] && !io_a.write;
      r_b_rvalid <= w_gnt[1] && !io_b.write;
      case (r_state)
        StRstIdle: begin
          r_cnt <= '0;
          if (INIT_ZERO != 0) begin
            r_state <= StInit;
          end else begin
            r_state     <= StRun;
            r_init_done <= 1'b1;
          end
        end
        StInit: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {AW{1'b1}}) begin
            r_state     <= StRun;
            r_init_done <= 1'b1;
          end
        end
        StRun: begin
          if (i_volt_req != r_volt_sel) begin
            r_state <= StVSwitch;
          end
        end
        StVSwitch: begin
          // Entered only on a mismatch and later volt_req edges are ignored
          // here, so toggling lands on the level that triggered the switch.
          r_volt_sel <= ~r_volt_sel;
          r_settle   <= SW'(SETTLE_CYCLES - 1);
          r_state    <= StVSettle;
        end
        StVSettle: begin
          if (r_settle == '0) begin
            r_state <= StRun;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        default: r_state <= StRstIdle;
      endcase
    end
  end

endmodule
